// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: FIFO read side and UART line bundle for the TX serializer
// rdataf/eflagf come from the TX FIFO; renf goes back to it.
// tx/busy/word_done are the serializer's line and status outputs.
interface uart_tx_serializer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] rdataf;
    logic             eflagf;
    logic             renf;
    logic             tx;
    logic             busy;
    logic             word_done;
    modport master (output rdataf, eflagf, input renf, tx, busy, word_done);
    modport slave  (input rdataf, eflagf, output renf, tx, busy, word_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops WIDTH-bit words from the TX FIFO and sends them as 8N1 frames, LSB byte first
// r_clk  : FIFO read-domain clock
// reset  : asynchronous active-high reset
// bus    : slave side of uart_tx_serializer_if (rdataf, eflagf in; renf, tx, busy, word_done out)
module uart_tx_serializer #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input logic                 r_clk,
    input logic                 reset,
    uart_tx_serializer_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int BW     = $clog2(CLKS_PER_BIT);
    localparam int CW     = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;
    logic [2:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    byte_cnt;
    logic [2:0]       bit_cnt;
    logic [BW-1:0]    baud;
    logic             bit_end;
    logic             last_byte;
    assign bit_end   = baud == BW'(CLKS_PER_BIT - 1);
    assign last_byte = byte_cnt == CW'(NBYTES - 1);
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            baud          <= '0;
            bus.tx        <= 1'b1;
            bus.renf      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.word_done <= 1'b0;
        end else begin
            bus.renf      <= 1'b0;
            // registered pulse: set one cycle early so it lands in the final stop cycle
            bus.word_done <= state == STOP && last_byte && baud == BW'(CLKS_PER_BIT - 2);
            case (state)
                IDLE: if (!bus.eflagf) begin
                    state    <= RD;
                    bus.renf <= 1'b1;
                    bus.busy <= 1'b1;
                end
                RD: state <= WAIT;
                WAIT: begin
                    shreg    <= bus.rdataf;
                    byte_cnt <= '0;
                    bit_cnt  <= '0;
                    baud     <= '0;
                    bus.tx   <= 1'b0;
                    state    <= START;
                end
                START: if (bit_end) begin
                    baud   <= '0;
                    bus.tx <= shreg[0];
                    state  <= DATA;
                end else baud <= baud + 1'b1;
                DATA: if (bit_end) begin
                    baud    <= '0;
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    bus.tx  <= bit_cnt == 3'd7 ? 1'b1 : shreg[1];
                    state   <= bit_cnt == 3'd7 ? STOP : DATA;
                end else baud <= baud + 1'b1;
                STOP: if (bit_end) begin
                    baud <= '0;
                    if (last_byte) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                        bus.tx   <= 1'b0;
                        state    <= START;
                    end
                end else baud <= baud + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed/random checks of the TX serializer against a line-timeline model
module tb_uart_tx_serializer;
    localparam int W  = 32;
    localparam int C  = 4;
    localparam int NB = W / 8;
    localparam int N  = NB * 10 * C;
    localparam int L  = 4096;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    uart_tx_serializer_if #(.WIDTH(W)) bif ();
    uart_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .r_clk (clk),
        .reset (reset),
        .bus   (bif)
    );
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pushes = 0;
    logic tx_l [L];
    logic renf_l [L];
    logic busy_l [L];
    logic wd_l [L];
    logic [W-1:0] q [$];
    logic [W-1:0] pend_word;
    logic pending = 1'b0;
    logic hide    = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one cycle: sample outputs at the falling edge, then play the FIFO (data one cycle after renf)
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cyc >= L) begin
            $display("FAIL cycle_budget observed %0d expected below %0d", cyc, L);
            $fatal(1, "cycle budget exhausted");
        end
        tx_l[cyc]   = bif.tx;
        renf_l[cyc] = bif.renf;
        busy_l[cyc] = bif.busy;
        wd_l[cyc]   = bif.word_done;
        chk("renf_while_empty", W'(bif.renf & bif.eflagf), '0);
        bif.rdataf = pending ? pend_word : W'($urandom);
        pending    = 1'b0;
        if (bif.renf === 1'b1 && q.size() > 0) begin
            pend_word = q.pop_front();
            pending   = 1'b1;
        end
        bif.eflagf = (q.size() == 0) || hide;
    endtask

    task automatic push(input logic [W-1:0] w);
        q.push_back(w);
        pushes++;
        bif.eflagf = hide;
    endtask

    // expected line level k cycles into a word: start, 8 data LSB first, stop, per byte
    function automatic logic exp_tx(input logic [W-1:0] w, input int k);
        int b = k / (10 * C);
        int s = (k % (10 * C)) / C;
        return s == 0 ? 1'b0 : s == 9 ? 1'b1 : w[b * 8 + s - 1];
    endfunction

    // r = cycle in which renf is expected for word w
    task automatic check_word(input int r, input logic [W-1:0] w, input string tag);
        logic [7:0] v;
        chk({tag, "_renf"}, W'(renf_l[r]), W'(1));
        chk({tag, "_renf_once"}, W'(renf_l[r + 1]), '0);
        chk({tag, "_busy_rise"}, W'(busy_l[r]), W'(1));
        chk({tag, "_idle_tx0"}, W'(tx_l[r]), W'(1));
        chk({tag, "_idle_tx1"}, W'(tx_l[r + 1]), W'(1));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_tx%0d", tag, k), W'(tx_l[r + 2 + k]), W'(exp_tx(w, k)));
            chk($sformatf("%s_wd%0d", tag, k), W'(wd_l[r + 2 + k]), W'(k == N - 1));
            chk($sformatf("%s_busy%0d", tag, k), W'(busy_l[r + 2 + k]), W'(1));
            chk($sformatf("%s_renf%0d", tag, k), W'(renf_l[r + 2 + k]), '0);
        end
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < 8; i++) v[i] = tx_l[r + 2 + b * 10 * C + (i + 1) * C + C / 2];
            chk($sformatf("%s_byte%0d", tag, b), W'(v), W'(w[b * 8 +: 8]));
        end
        chk({tag, "_busy_fall"}, W'(busy_l[r + 2 + N]), '0);
        chk({tag, "_wd_end"}, W'(wd_l[r + 2 + N]), '0);
        chk({tag, "_tx_end"}, W'(tx_l[r + 2 + N]), W'(1));
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] w2;
        int r;
        int c0;
        int target;
        int nrenf;
        bif.eflagf = 1'b1;
        bif.rdataf = '0;
        repeat (3) tick();
        chk("rst_tx", W'(bif.tx), W'(1));
        chk("rst_renf", W'(bif.renf), '0);
        chk("rst_busy", W'(bif.busy), '0);
        chk("rst_wd", W'(bif.word_done), '0);
        reset = 1'b0;
        c0 = cyc;
        repeat (100) tick();
        for (int i = c0 + 1; i <= cyc; i++) begin
            chk("idle_tx", W'(tx_l[i]), W'(1));
            chk("idle_renf", W'(renf_l[i]), '0);
            chk("idle_busy", W'(busy_l[i]), '0);
        end
        w = 32'hA55A_3C01;
        push(w);
        r = cyc + 1;
        repeat (N + 6) tick();
        check_word(r, w, "single");
        for (int j = 0; j < 2; j++) begin
            w = W'($urandom);
            push(w);
            r = cyc + 1;
            repeat (N + 6) tick();
            check_word(r, w, "rand");
        end
        push(32'h0000_00FF);
        push(32'hFFFF_FF00);
        r = cyc + 1;
        repeat (2 * N + 12) tick();
        check_word(r, 32'h0000_00FF, "b2b1");
        check_word(r + N + 3, 32'hFFFF_FF00, "b2b2");
        w  = W'($urandom);
        w2 = W'($urandom);
        push(w);
        push(w2);
        r = cyc + 1;
        repeat (N - 10) begin
            hide = 1'($urandom_range(0, 1));
            tick();
        end
        hide = 1'b0;
        repeat (N + 20) tick();
        check_word(r, w, "tog1");
        check_word(r + N + 3, w2, "tog2");
        w = W'($urandom) & 32'hFF00_FFFF;
        push(w);
        r = cyc + 1;
        target = r + 2 + 2 * 10 * C + C + 3 * C + 1;
        while (cyc < target) tick();
        chk("pre_rst_tx", W'(bif.tx), '0);
        chk("pre_rst_busy", W'(bif.busy), W'(1));
        #1 reset = 1'b1;
        #1;
        chk("async_rst_tx", W'(bif.tx), W'(1));
        chk("async_rst_renf", W'(bif.renf), '0);
        chk("async_rst_busy", W'(bif.busy), '0);
        chk("async_rst_wd", W'(bif.word_done), '0);
        repeat (3) tick();
        chk("held_rst_tx", W'(bif.tx), W'(1));
        chk("held_rst_busy", W'(bif.busy), '0);
        reset = 1'b0;
        w = W'($urandom);
        push(w);
        r = cyc + 1;
        repeat (N + 6) tick();
        check_word(r, w, "post_rst");
        nrenf = 0;
        for (int i = 1; i <= cyc; i++) nrenf += int'(renf_l[i]);
        chk("renf_total", W'(nrenf), W'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
